// File: rtl/sw_batch_sequencer.sv
// Smith-Waterman batch sequencer: queues scoring parameter sets, runs optional set-t then one start/drain per set.
// start_cal two cycles after i_go; pushes accepted only in IDLE with room, a wait longer than TIMEOUT aborts to ERR.
module sw_batch_sequencer #(
   parameter int PARAM_W  = 16,
   parameter int RESULT_W = 16,
   parameter int DEPTH    = 4,
   parameter int TIMEOUT  = 50000000,
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_param_valid,
   input  logic [PARAM_W-1:0]  i_param,
   output logic                o_param_ready,
   input  logic                i_go,
   input  logic                i_set_t_en,
   input  logic                i_clear,
   output logic                o_set_t,
   output logic                o_start_cal,
   output logic [PARAM_W-1:0]  o_param,
   input  logic                i_core_busy,
   input  logic                i_core_valid,
   input  logic [RESULT_W-1:0] i_core_result,
   output logic                o_res_valid,
   output logic [IDX_W-1:0]    o_res_idx,
   output logic [RESULT_W-1:0] o_result,
   output logic [RESULT_W-1:0] o_max_result,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_timeout,
   output logic [CNT_W-1:0]    o_count
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_SET_T, S_GUARD_T, S_WAIT_T, S_LOAD,
      S_START, S_WAIT_V, S_WAIT_B, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [PARAM_W-1:0]  mem_q [DEPTH];
   logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]    run_idx_q, run_idx_d, res_idx_q, res_idx_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PARAM_W-1:0]  param_q, param_d;
   logic [RESULT_W-1:0] result_q, result_d, max_q, max_d;
   logic                res_valid_q, res_valid_d, empty_done_q, empty_done_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                push, pop, flush, wd_expired, in_run, is_wait;

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   assign o_param_ready = rst_n && (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH));
   assign push          = i_param_valid && o_param_ready;
   assign wd_expired    = (wd_q == WD_W'(TIMEOUT - 1));
   assign in_run        = (state_q == S_LOAD) || (state_q == S_START) ||
                          (state_q == S_WAIT_V) || (state_q == S_WAIT_B);
   assign is_wait       = (state_d == S_WAIT_T) || (state_d == S_WAIT_V) || (state_d == S_WAIT_B);

   always_comb begin
      state_d      = state_q;
      run_idx_d    = run_idx_q;
      result_d     = result_q;
      res_idx_d    = res_idx_q;
      res_valid_d  = 1'b0;
      max_d        = max_q;
      empty_done_d = 1'b0;
      param_d      = param_q;
      pop          = 1'b0;
      flush        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_go) begin
               if (count_q != '0) begin
                  max_d     = '0;
                  run_idx_d = '0;
                  state_d   = i_set_t_en ? S_SET_T : S_LOAD;
               end else begin
                  empty_done_d = 1'b1;
               end
            end
         end
         S_SET_T:   state_d = S_GUARD_T;
         S_GUARD_T: state_d = S_WAIT_T;
         S_WAIT_T: begin
            if (!i_core_busy) begin
               state_d = S_LOAD;
            end else if (wd_expired) begin
               state_d = S_ERR;
               flush   = 1'b1;
            end
         end
         S_LOAD: begin
            param_d = mem_q[rd_ptr_q];
            state_d = S_START;
         end
         S_START: state_d = S_WAIT_V;
         S_WAIT_V: begin
            // A result that arrives together with busy low skips WAIT_B entirely.
            if (i_core_valid) begin
               result_d    = i_core_result;
               res_idx_d   = run_idx_q;
               res_valid_d = 1'b1;
               if (i_core_result > max_q) max_d = i_core_result;
               if (!i_core_busy) pop = 1'b1;
               else              state_d = S_WAIT_B;
            end else if (wd_expired) begin
               state_d = S_ERR;
               flush   = 1'b1;
            end
         end
         S_WAIT_B: begin
            if (!i_core_busy) begin
               pop = 1'b1;
            end else if (wd_expired) begin
               state_d = S_ERR;
               flush   = 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_ERR:  if (i_clear) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         run_idx_d = run_idx_q + IDX_W'(1);
         state_d   = (count_q == CNT_W'(1)) ? S_DONE : S_LOAD;
      end
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) begin
            count_d  = count_q + CNT_W'(1);
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            count_d  = count_q - CNT_W'(1);
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
      end
      wd_d = (is_wait && (state_d == state_q)) ? wd_q + WD_W'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= i_param;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         run_idx_q    <= '0;
         res_idx_q    <= '0;
         result_q     <= '0;
         max_q        <= '0;
         res_valid_q  <= 1'b0;
         empty_done_q <= 1'b0;
         param_q      <= '0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         run_idx_q    <= run_idx_d;
         res_idx_q    <= res_idx_d;
         result_q     <= result_d;
         max_q        <= max_d;
         res_valid_q  <= res_valid_d;
         empty_done_q <= empty_done_d;
         param_q      <= param_d;
         wd_q         <= wd_d;
      end
   end

   // During a run the head entry drives the core directly; elsewhere the last loaded set is held.
   assign o_param      = in_run ? mem_q[rd_ptr_q] : param_q;
   assign o_set_t      = (state_q == S_SET_T);
   assign o_start_cal  = (state_q == S_START);
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = (state_q == S_DONE) || empty_done_q;
   assign o_timeout    = (state_q == S_ERR);
   assign o_count      = count_q;
   assign o_res_valid  = res_valid_q;
   assign o_res_idx    = res_idx_q;
   assign o_result     = result_q;
   assign o_max_result = max_q;

endmodule

// File: tb/tb_sw_batch_sequencer.sv
// Bench for sw_batch_sequencer: behavioural core model, param/result scoreboards and directed batch scenarios.
module tb_sw_batch_sequencer;
   localparam int PARAM_W  = 16;
   localparam int RESULT_W = 16;
   localparam int DEPTH    = 4;
   localparam int TIMEOUT  = 100;
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                i_param_valid, i_go, i_set_t_en, i_clear;
   logic [PARAM_W-1:0]  i_param;
   logic                o_param_ready, o_set_t, o_start_cal;
   logic [PARAM_W-1:0]  o_param;
   logic                i_core_busy, i_core_valid;
   logic [RESULT_W-1:0] i_core_result;
   logic                o_res_valid;
   logic [IDX_W-1:0]    o_res_idx;
   logic [RESULT_W-1:0] o_result, o_max_result;
   logic                o_busy, o_done, o_timeout;
   logic [CNT_W-1:0]    o_count;

   sw_batch_sequencer #(
      .PARAM_W(PARAM_W), .RESULT_W(RESULT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_param_valid(i_param_valid), .i_param(i_param), .o_param_ready(o_param_ready),
      .i_go(i_go), .i_set_t_en(i_set_t_en), .i_clear(i_clear),
      .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_param(o_param),
      .i_core_busy(i_core_busy), .i_core_valid(i_core_valid), .i_core_result(i_core_result),
      .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_result(o_result),
      .o_max_result(o_max_result), .o_busy(o_busy), .o_done(o_done),
      .o_timeout(o_timeout), .o_count(o_count)
   );

   typedef struct packed {
      logic [IDX_W-1:0]    idx;
      logic [RESULT_W-1:0] res;
   } exp_res_t;

   typedef struct {
      logic [PARAM_W-1:0]  param;
      logic                exp_ready;
      logic [CNT_W-1:0]    exp_count;
      logic [RESULT_W-1:0] res;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int set_t_cnt = 0, start_cnt = 0, done_cnt = 0, resv_cnt = 0;
   int last_start_cyc = 0, start_gap = 0;
   int model_cnt = 0;
   bit core_mute = 1'b0, core_same = 1'b0;
   logic [PARAM_W-1:0]  prev_param = '0;
   logic [PARAM_W-1:0]  exp_param_q[$];
   exp_res_t            exp_res_q[$];
   logic [RESULT_W-1:0] core_res_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [PARAM_W-1:0] p, input logic exp_ready);
      chk("param_ready", o_param_ready, exp_ready);
      i_param_valid = 1'b1;
      i_param       = p;
      tick();
      i_param_valid = 1'b0;
      if (exp_ready) begin
         exp_param_q.push_back(p);
         model_cnt++;
      end
   endtask

   task automatic add_result(input logic [RESULT_W-1:0] r, input int idx);
      core_res_q.push_back(r);
      exp_res_q.push_back({IDX_W'(idx), r});
   endtask

   task automatic go(input logic set_t_en);
      i_go       = 1'b1;
      i_set_t_en = set_t_en;
      tick();
      i_go       = 1'b0;
      i_set_t_en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < 300) begin
         tick();
         n++;
      end
      chk(name, 32'(done_cnt != d0), 1);
      model_cnt = 0;
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!o_start_cal && n < 20) begin
         tick();
         n++;
      end
      chk(name, o_start_cal, 1'b1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Core model: busy after set_t/start_cal, result a few cycles later, busy drop after it.
   initial begin
      int cdly = 0;
      int cph  = 0;
      i_core_busy = 1'b0; i_core_valid = 1'b0; i_core_result = '0;
      forever begin
         tick();
         i_core_valid = 1'b0;
         if (!rst_n) begin
            i_core_busy = 1'b0; cph = 0; cdly = 0;
         end else if (o_timeout) begin
            i_core_busy = 1'b0; cph = 0;
         end else if (o_set_t) begin
            i_core_busy = 1'b1; cph = 1; cdly = 3;
         end else if (o_start_cal) begin
            i_core_busy = 1'b1; cph = 2; cdly = 4;
         end else if (cph != 0 && cdly > 0) begin
            cdly--;
            if (cdly == 0) begin
               case (cph)
                  1: begin i_core_busy = 1'b0; cph = 0; end
                  2: begin
                     cph = 0;
                     if (!core_mute) begin
                        i_core_valid  = 1'b1;
                        i_core_result = (core_res_q.size() > 0) ? core_res_q.pop_front() : '0;
                        if (core_same) i_core_busy = 1'b0;
                        else begin cph = 3; cdly = 1; end
                     end
                  end
                  default: begin i_core_busy = 1'b0; cph = 0; end
               endcase
            end
         end
      end
   end

   // Output monitor sampled mid-cycle, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (o_set_t) set_t_cnt++;
         if (o_done)  done_cnt++;
         if (o_start_cal) begin
            start_cnt++;
            start_gap      = cyc - last_start_cyc;
            last_start_cyc = cyc;
            chk("param_setup_stable", o_param, prev_param);
            if (exp_param_q.size() == 0) chk("unexpected_start_cal", 1, 0);
            else                         chk("start_param", o_param, exp_param_q.pop_front());
         end
         if (o_res_valid) begin
            exp_res_t e;
            resv_cnt++;
            if (exp_res_q.size() == 0) begin
               chk("unexpected_res_valid", 1, 0);
            end else begin
               e = exp_res_q.pop_front();
               chk("res_idx", o_res_idx, e.idx);
               chk("result", o_result, e.res);
            end
         end
      end
      prev_param = o_param;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      vec_t tbl[5];
      int s0, r0, d0, n;
      tbl[0] = '{16'h3141, 1'b1, 3'd1, 16'd3};
      tbl[1] = '{16'h5926, 1'b1, 3'd2, 16'd8};
      tbl[2] = '{16'h5358, 1'b1, 3'd3, 16'd8};
      tbl[3] = '{16'h9793, 1'b1, 3'd4, 16'd1};
      tbl[4] = '{16'h2384, 1'b0, 3'd4, 16'd0};

      rst_n = 1'b0; i_param_valid = 1'b0; i_param = '0;
      i_go = 1'b0; i_set_t_en = 1'b0; i_clear = 1'b0;
      #23;
      chk("rst_busy", o_busy, 0);
      chk("rst_count", o_count, 0);
      chk("rst_ready", o_param_ready, 0);
      chk("rst_param", o_param, 0);
      chk("rst_max", o_max_result, 0);
      chk("rst_done", o_done, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_ready", o_param_ready, 1);

      // Two runs with set-t phase.
      push(16'h2311, 1'b1);
      push(16'h1222, 1'b1);
      add_result(16'd17, 0);
      add_result(16'd9, 1);
      s0 = set_t_cnt; r0 = start_cnt;
      go(1'b1);
      wait_done("t1_done");
      chk("t1_set_t_pulses", set_t_cnt - s0, 1);
      chk("t1_start_pulses", start_cnt - r0, 2);
      chk("t1_max", o_max_result, 17);
      chk("t1_busy_after", o_busy, 0);

      // Fill past DEPTH from the table, then run with start_cal timing check.
      for (int i = 0; i < 5; i++) begin
         push(tbl[i].param, tbl[i].exp_ready);
         chk("fill_count", o_count, tbl[i].exp_count);
         if (tbl[i].exp_ready) add_result(tbl[i].res, i);
      end
      chk("full_ready_low", o_param_ready, 0);
      r0 = start_cnt;
      go(1'b0);
      chk("load_busy", o_busy, 1);
      chk("load_no_start", o_start_cal, 0);
      chk("load_param_head", o_param, tbl[0].param);
      tick();
      chk("start_cycle2", o_start_cal, 1);
      wait_done("t2_done");
      chk("t2_start_pulses", start_cnt - r0, 4);
      chk("t2_max", o_max_result, 8);
      chk("t2_last_idx", o_res_idx, 3);
      chk("t2_count", o_count, 0);

      // Next batch reads wrapped entries.
      push(16'h0BEE, 1'b1);
      push(16'h0C0D, 1'b1);
      add_result(16'd200, 0);
      add_result(16'd5, 1);
      go(1'b0);
      wait_done("t3_done");
      chk("t3_max", o_max_result, 200);

      // Empty-queue go.
      s0 = set_t_cnt; r0 = start_cnt; d0 = done_cnt;
      go(1'b1);
      chk("empty_done_pulse", o_done, 1);
      chk("empty_busy", o_busy, 0);
      tick();
      chk("empty_done_low", o_done, 0);
      chk("empty_busy2", o_busy, 0);
      chk("empty_no_core", (set_t_cnt - s0) + (start_cnt - r0), 0);
      chk("empty_one_done", done_cnt - d0, 1);

      // Watchdog: core never returns a result.
      core_mute = 1'b1;
      push(16'h4444, 1'b1);
      d0 = done_cnt;
      go(1'b0);
      wait_start("to_start");
      n = 0;
      while (!o_timeout && n < 200) begin
         tick();
         n++;
      end
      chk("to_cycles", n, TIMEOUT + 1);
      chk("to_flag", o_timeout, 1);
      chk("to_busy", o_busy, 1);
      chk("to_count", o_count, 0);
      model_cnt = 0;
      tick();
      tick();
      chk("to_sticky", o_timeout, 1);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("clr_timeout", o_timeout, 0);
      chk("clr_busy", o_busy, 0);
      chk("to_no_done", done_cnt - d0, 0);
      core_mute = 1'b0;

      // Valid and busy-drop in the same cycle.
      core_same = 1'b1;
      push(16'h1111, 1'b1);
      push(16'h2222, 1'b1);
      add_result(16'd21, 0);
      add_result(16'd34, 1);
      go(1'b0);
      wait_done("same_done");
      chk("same_start_gap", start_gap, 6);
      chk("same_max", o_max_result, 34);
      core_same = 1'b0;

      // Asynchronous reset mid-run.
      core_mute = 1'b1;
      push(16'h5555, 1'b1);
      go(1'b0);
      wait_start("rst_start");
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_count", o_count, 0);
      chk("mid_rst_max", o_max_result, 0);
      chk("mid_rst_result", o_result, 0);
      chk("mid_rst_param", o_param, 0);
      chk("mid_rst_start", o_start_cal, 0);
      model_cnt = 0;
      tick();
      rst_n = 1'b1;
      core_mute = 1'b0;
      tick();
      push(16'h00AB, 1'b1);
      chk("post_rst_count", o_count, 1);
      add_result(16'd42, 0);
      go(1'b0);
      wait_done("post_rst_done");
      chk("post_rst_max", o_max_result, 42);

      tick();
      chk("param_sb_empty", exp_param_q.size(), 0);
      chk("result_sb_empty", exp_res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
